imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Writer side of the instruction memory: receives a program as a byte stream,
//  assembles little-endian 32-bit instruction words and writes them to
//  consecutive word addresses of ins_mem. It holds the core (fetch/decode/
//  execute) stalled while loading, so ins_mem/decode only see a complete program.
// PARAMETERS
//  N_param      32   instruction/data word width (fixed at 32; 4 bytes/word)
//  DEPTH_WORDS  256  instruction memory depth in words
//  ADDR_W       8    word-address width, = clog2(DEPTH_WORDS)
// PORTS
//  clk           in   1          system clock, all logic on rising edge
//  reset         in   1          synchronous, active-low reset
//  start_i       in   1          single-cycle request to begin a load
//  len_words_i   in   ADDR_W+1   program length in words, sampled on accepted start_i
//  byte_valid_i  in   1          byte_data_i is valid
//  byte_data_i   in   8          program byte, stream order = increasing byte address
//  byte_ready_o  out  1          loader accepts a byte this cycle
//  mem_we_o      out  1          instruction memory write strobe
//  mem_addr_o    out  ADDR_W     word address of the write
//  mem_wdata_o   out  N_param    instruction word to write
//  busy_o        out  1          load in progress
//  core_hold_o   out  1          stall the core; equal to busy_o
//  done_o        out  1          one-cycle pulse: last word written
//  err_o         out  1          sticky: last start_i had an illegal length
// BEHAVIOUR
//  - Reset (reset==0 at a clk edge): state IDLE; all outputs 0; word/byte
//    counters and assembly register cleared; a partial word is discarded, no write.
//  - FSM states IDLE, COLLECT, WRITE, DONE.
//  - IDLE: byte_ready_o=0. On start_i: if len_words_i==0 or >DEPTH_WORDS,
//    set err_o=1 and stay IDLE; else clear err_o, latch length, word_cnt=0,
//    byte_idx=0, go to COLLECT. busy_o/core_hold_o rise the next cycle.
//  - COLLECT: byte_ready_o=1. A byte is accepted when byte_valid_i & byte_ready_o.
//    Accepted byte k (0..3) goes to word bits [8k+7:8k]; byte 0 is the LSB.
//    Idle cycles (valid low) keep state. After byte 3 is accepted, go to WRITE.
//  - WRITE: exactly one cycle; byte_ready_o=0; mem_we_o=1,
//    mem_addr_o=word_cnt, mem_wdata_o=assembled word. Then, if
//    word_cnt==len-1, go to DONE; else word_cnt++, byte_idx=0, go to COLLECT.
//  - DONE: done_o=1 for one cycle; busy_o=0 from this cycle; go to IDLE.
//  - mem_addr_o/mem_wdata_o are 0 when mem_we_o=0.
//  - Throughput: at most one word per 5 cycles (4 accept cycles + 1 WRITE).
//  - start_i is ignored unless the state is IDLE; err_o is unchanged by it.
//  - len==DEPTH_WORDS: last write is to address DEPTH_WORDS-1. word_cnt never
//    wraps and no write goes beyond the latched length.
//  - Bytes offered while IDLE/WRITE/DONE are not accepted (ready low). Source
//    must hold the byte until accepted.
//  - Reset wins over every other event in the same cycle.
// TESTING
//  1 Reset: hold reset=0 3 cycles with random inputs -> all outputs 0, no mem_we_o.
//  2 Load len=2, bytes 13 00 00 00 93 00 10 00 with valid always high ->
//    write addr0=0x00000013, addr1=0x00100093, done_o one cycle after 2nd
//    write, busy_o high exactly 10 cycles.
//  3 Same program with valid dropped on random cycles -> identical writes;
//    each byte accepted exactly once.
//  4 start_i with len=0, then with len=DEPTH_WORDS+1 -> err_o=1, busy_o=0,
//    no writes; next legal start clears err_o.
//  5 Reset asserted after 2 bytes of word 1 -> no write, IDLE; a re-load
//    writes the correct word; a start_i pulsed mid-load is ignored.
//  6 len=DEPTH_WORDS, word i = i -> DEPTH_WORDS writes, last at addr
//    DEPTH_WORDS-1, single done_o pulse, no extra write.

Source files
------------

// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//   Writer side of the instruction memory. Receives a program as a byte
//   stream, assembles little-endian 32-bit words and writes them to
//   consecutive word addresses starting at 0. The core is held stalled for
//   the whole load so it only ever sees a complete program.
//
// Ports
//   clk           system clock, rising edge
//   reset         synchronous, active-low reset
//   start_i       single-cycle load request (only honoured when idle)
//   len_words_i   program length in words, sampled on an accepted start_i
//   byte_valid_i  byte_data_i carries a program byte
//   byte_data_i   program byte, stream order = increasing byte address
//   byte_ready_o  loader accepts a byte this cycle
//   mem_we_o      instruction memory write strobe
//   mem_addr_o    word address of the write (0 when not writing)
//   mem_wdata_o   instruction word to write (0 when not writing)
//   busy_o        load in progress
//   core_hold_o   core stall request, identical to busy_o
//   done_o        one-cycle pulse after the last word was written
//   err_o         sticky: the last honoured start_i had an illegal length
// ---------------------------------------------------------------------------
module imem_loader #(
    parameter int N_param     = 32,
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_i,
    input  logic [ADDR_W:0]     len_words_i,
    input  logic                byte_valid_i,
    input  logic [7:0]          byte_data_i,
    output logic                byte_ready_o,
    output logic                mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [N_param-1:0]  mem_wdata_o,
    output logic                busy_o,
    output logic                core_hold_o,
    output logic                done_o,
    output logic                err_o
);

    localparam int BYTES  = N_param / 8;
    localparam int BIDX_W = $clog2(BYTES);

    localparam logic [ADDR_W:0]   DEPTH_LEN = (ADDR_W + 1)'(DEPTH_WORDS);
    localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W + 1)'(1);
    localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        WRITE,
        DONE
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_W:0]       len_q, len_d;
    logic [ADDR_W-1:0]     word_cnt_q, word_cnt_d;
    logic [BIDX_W-1:0]     byte_idx_q, byte_idx_d;
    logic [N_param-1:0]    asm_q, asm_d;
    logic                  err_q, err_d;

    logic                  byte_ready_q, byte_ready_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [N_param-1:0]    mem_wdata_q, mem_wdata_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic                  len_ok;
    logic                  byte_accept;
    logic                  last_word;

    assign len_ok      = (len_words_i != '0) && (len_words_i <= DEPTH_LEN);
    assign byte_accept = byte_valid_i & byte_ready_q;
    // word_cnt only ever reaches len-1, so it never wraps past the program.
    assign last_word   = ({1'b0, word_cnt_q} == (len_q - LEN_ONE));

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_cnt_d = word_cnt_q;
        byte_idx_d = byte_idx_q;
        asm_d      = asm_q;
        err_d      = err_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    if (len_ok) begin
                        err_d      = 1'b0;
                        len_d      = len_words_i;
                        word_cnt_d = '0;
                        byte_idx_d = '0;
                        asm_d      = '0;
                        state_d    = COLLECT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (byte_accept) begin
                    // Byte k lands in bits [8k+7:8k]: little-endian assembly.
                    asm_d[{byte_idx_q, 3'b000} +: 8] = byte_data_i;
                    byte_idx_d = byte_idx_q + 1'b1;
                    if (byte_idx_q == LAST_BYTE) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                if (last_word) begin
                    state_d = DONE;
                end else begin
                    word_cnt_d = word_cnt_q + 1'b1;
                    byte_idx_d = '0;
                    asm_d      = '0;
                    state_d    = COLLECT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered: decode the next state so each registered
    // output lines up with the state it belongs to.
    always_comb begin
        byte_ready_d = (state_d == COLLECT);
        mem_we_d     = (state_d == WRITE);
        mem_addr_d   = mem_we_d ? word_cnt_d : '0;
        mem_wdata_d  = mem_we_d ? asm_d : '0;
        busy_d       = (state_d == COLLECT) || (state_d == WRITE);
        done_d       = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            len_q        <= '0;
            word_cnt_q   <= '0;
            byte_idx_q   <= '0;
            asm_q        <= '0;
            err_q        <= 1'b0;
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_cnt_q   <= word_cnt_d;
            byte_idx_q   <= byte_idx_d;
            asm_q        <= asm_d;
            err_q        <= err_d;
            byte_ready_q <= byte_ready_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign byte_ready_o = byte_ready_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign busy_o       = busy_q;
    assign core_hold_o  = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// ---------------------------------------------------------------------------
// tb_imem_loader
//   Self-checking bench for imem_loader. A byte source drives programs with
//   randomly dropped valid cycles; every write, busy/done/err behaviour and
//   handshake is compared against words computed directly from the byte
//   stream (word i = bytes 4i..4i+3, little-endian, at address i).
// ---------------------------------------------------------------------------
module tb_imem_loader;

    localparam int N     = 32;
    localparam int DEPTH = 256;
    localparam int AW    = 8;

    logic           clk = 1'b0;
    logic           reset;
    logic           start_i;
    logic [AW:0]    len_words_i;
    logic           byte_valid_i;
    logic [7:0]     byte_data_i;
    logic           byte_ready_o;
    logic           mem_we_o;
    logic [AW-1:0]  mem_addr_o;
    logic [N-1:0]   mem_wdata_o;
    logic           busy_o;
    logic           core_hold_o;
    logic           done_o;
    logic           err_o;

    imem_loader #(
        .N_param     (N),
        .DEPTH_WORDS (DEPTH),
        .ADDR_W      (AW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start_i),
        .len_words_i  (len_words_i),
        .byte_valid_i (byte_valid_i),
        .byte_data_i  (byte_data_i),
        .byte_ready_o (byte_ready_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .busy_o       (busy_o),
        .core_hold_o  (core_hold_o),
        .done_o       (done_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  prog[$];
    int          wr_addr[$];
    logic [31:0] wr_data[$];
    int          exp_a[$];
    logic [31:0] exp_d[$];

    int busy_cycles, done_cnt, done_bad, accepted;
    int zero_viol, hold_viol, ready_viol, timed_out;

    // Reference: word i is the little-endian sum of bytes 4i..4i+3.
    task automatic build_model(input int len);
        exp_a.delete();
        exp_d.delete();
        for (int i = 0; i < len; i++) begin
            exp_a.push_back(i);
            exp_d.push_back(32'(prog[4*i]) + 32'(prog[4*i+1]) * 256 +
                            32'(prog[4*i+2]) * 65536 + 32'(prog[4*i+3]) * 16777216);
        end
    endtask

    // Starts a load and streams prog[]. Samples outputs on falling edges.
    // stop_after >= 0: return once that many bytes were accepted.
    // mid_start_at >= 0: pulse start_i (len 0) on that cycle of the load.
    task automatic run_load(input int len, input int drop_pct, input int stop_after,
                            input int mid_start_at, input int budget);
        int bptr = 0;
        int cyc = 0;
        bit last_we = 1'b0;
        wr_addr.delete();
        wr_data.delete();
        busy_cycles = 0; done_cnt = 0; done_bad = 0; accepted = 0;
        zero_viol = 0; hold_viol = 0; ready_viol = 0; timed_out = 0;
        @(negedge clk);
        start_i      = 1'b1;
        len_words_i  = (AW + 1)'(len);
        byte_valid_i = 1'b0;
        forever begin
            @(negedge clk);
            start_i = (cyc == mid_start_at);
            if (cyc == mid_start_at) len_words_i = '0;
            if (mem_we_o) begin
                wr_addr.push_back(int'(mem_addr_o));
                wr_data.push_back(mem_wdata_o);
            end else if (mem_addr_o !== '0 || mem_wdata_o !== '0) begin
                zero_viol++;
            end
            if (core_hold_o !== busy_o) hold_viol++;
            if (byte_ready_o && (!busy_o || mem_we_o)) ready_viol++;
            if (busy_o) busy_cycles++;
            if (done_o) begin
                done_cnt++;
                if (!last_we) done_bad++;
            end
            last_we = mem_we_o;
            if (done_o) break;
            if (stop_after >= 0 && bptr == stop_after) begin
                byte_valid_i = 1'b0;
                start_i      = 1'b0;
                accepted     = bptr;
                return;
            end
            if (cyc >= budget) begin
                timed_out = 1;
                break;
            end
            if (bptr < prog.size() && $urandom_range(99) >= drop_pct) begin
                byte_valid_i = 1'b1;
                byte_data_i  = prog[bptr];
            end else begin
                byte_valid_i = 1'b0;
                byte_data_i  = 8'($urandom);
            end
            if (byte_valid_i && byte_ready_o) bptr++;
            cyc++;
        end
        accepted = bptr;
        // Keep offering bytes after the load: none may be accepted or written.
        start_i      = 1'b0;
        byte_valid_i = 1'b1;
        repeat (4) begin
            byte_data_i = 8'($urandom);
            @(negedge clk);
            if (mem_we_o) begin
                wr_addr.push_back(int'(mem_addr_o));
                wr_data.push_back(mem_wdata_o);
            end
            if (byte_ready_o) ready_viol++;
            if (done_o) done_cnt++;
            if (busy_o) busy_cycles++;
        end
        byte_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [N+AW+5:0] outs;
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            start_i      = 1'($urandom);
            len_words_i  = (AW + 1)'($urandom);
            byte_valid_i = 1'($urandom);
            byte_data_i  = 8'($urandom);
            @(negedge clk);
            outs = {byte_ready_o, mem_we_o, mem_addr_o, mem_wdata_o, busy_o, core_hold_o, done_o, err_o};
            checks++;
            if (outs !== '0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: outputs %h, expected 0", c, outs);
            end
        end
        start_i      = 1'b0;
        byte_valid_i = 1'b0;
        len_words_i  = '0;
        reset        = 1'b1;
    endtask

    task automatic test_basic_load();
        int bad = 0; int ga = 0; int ea = 0; logic [31:0] gd = '0; logic [31:0] ed = '0;
        prog = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        build_model(2);
        run_load(2, 0, -1, -1, 60);
        checks++;
        if (timed_out != 0) begin errors++; $display("FAIL basic_timeout: no done_o within budget, expected done"); end
        for (int i = 0; i < wr_addr.size() && i < exp_a.size(); i++)
            if (wr_addr[i] != exp_a[i] || wr_data[i] !== exp_d[i]) begin
                if (bad == 0) begin ga = wr_addr[i]; gd = wr_data[i]; ea = exp_a[i]; ed = exp_d[i]; end
                bad++;
            end
        checks++;
        if (bad != 0 || wr_addr.size() != exp_a.size()) begin
            errors++;
            $display("FAIL basic_writes: %0d writes (addr %0d data %h), expected %0d writes (addr %0d data %h)",
                     wr_addr.size(), ga, gd, exp_a.size(), ea, ed);
        end
        checks++;
        if (exp_d.size() != 2 || exp_d[0] !== 32'h0000_0013 || exp_d[1] !== 32'h0010_0093) begin
            errors++; $display("FAIL basic_model: model words not 00000013/00100093");
        end
        checks++;
        if (busy_cycles != 10) begin errors++; $display("FAIL basic_busy: busy for %0d cycles, expected 10", busy_cycles); end
        checks++;
        if (done_cnt != 1 || done_bad != 0) begin
            errors++; $display("FAIL basic_done: %0d pulses (%0d not after a write), expected 1 (0)", done_cnt, done_bad);
        end
        checks++;
        if (zero_viol != 0 || hold_viol != 0 || ready_viol != 0) begin
            errors++; $display("FAIL basic_handshake: zero %0d hold %0d ready %0d violations, expected 0", zero_viol, hold_viol, ready_viol);
        end
    endtask

    task automatic test_stalled_load();
        int bad = 0; int ga = 0; int ea = 0; logic [31:0] gd = '0; logic [31:0] ed = '0;
        prog = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        build_model(2);
        run_load(2, 40, -1, -1, 300);
        checks++;
        if (timed_out != 0) begin errors++; $display("FAIL stall_timeout: no done_o within budget, expected done"); end
        for (int i = 0; i < wr_addr.size() && i < exp_a.size(); i++)
            if (wr_addr[i] != exp_a[i] || wr_data[i] !== exp_d[i]) begin
                if (bad == 0) begin ga = wr_addr[i]; gd = wr_data[i]; ea = exp_a[i]; ed = exp_d[i]; end
                bad++;
            end
        checks++;
        if (bad != 0 || wr_addr.size() != exp_a.size()) begin
            errors++;
            $display("FAIL stall_writes: %0d writes (addr %0d data %h), expected %0d writes (addr %0d data %h)",
                     wr_addr.size(), ga, gd, exp_a.size(), ea, ed);
        end
        checks++;
        if (accepted != 8) begin errors++; $display("FAIL stall_accepted: %0d bytes accepted, expected 8", accepted); end
        checks++;
        if (busy_cycles < 10 || done_cnt != 1 || ready_viol != 0) begin
            errors++; $display("FAIL stall_timing: busy %0d done %0d ready_viol %0d, expected >=10, 1, 0", busy_cycles, done_cnt, ready_viol);
        end
    endtask

    task automatic test_illegal_len();
        int bad_cycles;
        int lens[2] = '{0, DEPTH + 1};
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            start_i     = 1'b1;
            len_words_i = (AW + 1)'(lens[k]);
            @(negedge clk);
            start_i = 1'b0;
            checks++;
            if (err_o !== 1'b1 || busy_o !== 1'b0) begin
                errors++; $display("FAIL illegal_err len=%0d: err %b busy %b, expected err 1 busy 0", lens[k], err_o, busy_o);
            end
            bad_cycles = 0;
            repeat (3) begin
                @(negedge clk);
                if (mem_we_o || busy_o || byte_ready_o) bad_cycles++;
            end
            checks++;
            if (bad_cycles != 0) begin
                errors++; $display("FAIL illegal_activity len=%0d: %0d active cycles, expected 0", lens[k], bad_cycles);
            end
        end
        prog.delete();
        for (int i = 0; i < 4; i++) prog.push_back(8'($urandom));
        build_model(1);
        run_load(1, 20, -1, -1, 100);
        checks++;
        if (err_o !== 1'b0) begin errors++; $display("FAIL illegal_clear: err %b after legal start, expected 0", err_o); end
        checks++;
        if (wr_addr.size() != 1 || timed_out != 0 || wr_addr[0] != 0 || wr_data[0] !== exp_d[0]) begin
            errors++; $display("FAIL illegal_reload: %0d writes, first data %h, expected 1 write data %h",
                               wr_addr.size(), (wr_data.size() > 0) ? wr_data[0] : 32'hx, exp_d[0]);
        end
    endtask

    task automatic test_reset_mid_load();
        int bad = 0; int ga = 0; int ea = 0; logic [31:0] gd = '0; logic [31:0] ed = '0;
        prog.delete();
        for (int i = 0; i < 8; i++) prog.push_back(8'($urandom));
        build_model(2);
        run_load(2, 0, 6, -1, 100);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_addr.size() != 1 || wr_data[0] !== exp_d[0]) begin
            errors++; $display("FAIL midreset_partial: %0d writes, expected 1 (word 0 = %h)", wr_addr.size(), exp_d[0]);
        end
        checks++;
        if ({mem_we_o, busy_o, byte_ready_o, done_o, mem_wdata_o} !== '0) begin
            errors++; $display("FAIL midreset_outputs: we %b busy %b ready %b done %b data %h, expected all 0",
                               mem_we_o, busy_o, byte_ready_o, done_o, mem_wdata_o);
        end
        reset = 1'b1;
        prog.delete();
        for (int i = 0; i < 8; i++) prog.push_back(8'($urandom));
        build_model(2);
        run_load(2, 20, -1, 3, 300);
        for (int i = 0; i < wr_addr.size() && i < exp_a.size(); i++)
            if (wr_addr[i] != exp_a[i] || wr_data[i] !== exp_d[i]) begin
                if (bad == 0) begin ga = wr_addr[i]; gd = wr_data[i]; ea = exp_a[i]; ed = exp_d[i]; end
                bad++;
            end
        checks++;
        if (bad != 0 || wr_addr.size() != exp_a.size() || timed_out != 0) begin
            errors++;
            $display("FAIL midreset_reload: %0d writes (addr %0d data %h), expected %0d writes (addr %0d data %h)",
                     wr_addr.size(), ga, gd, exp_a.size(), ea, ed);
        end
        checks++;
        if (err_o !== 1'b0 || done_cnt != 1) begin
            errors++; $display("FAIL midreset_start_ignored: err %b done %0d, expected err 0 done 1", err_o, done_cnt);
        end
    endtask

    task automatic test_full_depth();
        int bad = 0; int ga = 0; int ea = 0; logic [31:0] gd = '0; logic [31:0] ed = '0;
        prog.delete();
        for (int i = 0; i < DEPTH; i++) begin
            prog.push_back(8'(i));
            prog.push_back(8'h00);
            prog.push_back(8'h00);
            prog.push_back(8'h00);
        end
        build_model(DEPTH);
        run_load(DEPTH, 0, -1, -1, DEPTH * 5 + 20);
        for (int i = 0; i < wr_addr.size() && i < exp_a.size(); i++)
            if (wr_addr[i] != exp_a[i] || wr_data[i] !== exp_d[i]) begin
                if (bad == 0) begin ga = wr_addr[i]; gd = wr_data[i]; ea = exp_a[i]; ed = exp_d[i]; end
                bad++;
            end
        checks++;
        if (bad != 0 || wr_addr.size() != DEPTH || timed_out != 0) begin
            errors++;
            $display("FAIL full_writes: %0d writes (addr %0d data %h), expected %0d writes (addr %0d data %h)",
                     wr_addr.size(), ga, gd, DEPTH, ea, ed);
        end
        checks++;
        if (wr_addr.size() == 0 || wr_addr[wr_addr.size()-1] != DEPTH - 1) begin
            errors++; $display("FAIL full_last_addr: last address %0d, expected %0d",
                               (wr_addr.size() > 0) ? wr_addr[wr_addr.size()-1] : -1, DEPTH - 1);
        end
        checks++;
        if (done_cnt != 1 || busy_cycles != DEPTH * 5) begin
            errors++; $display("FAIL full_done: done %0d busy %0d, expected 1 and %0d", done_cnt, busy_cycles, DEPTH * 5);
        end
    endtask

    task automatic test_random_loads();
        for (int r = 0; r < 4; r++) begin
            int bad = 0;
            int len = $urandom_range(1, 8);
            int drop = $urandom_range(0, 50);
            prog.delete();
            for (int i = 0; i < 4 * len; i++) prog.push_back(8'($urandom));
            build_model(len);
            run_load(len, drop, -1, -1, 400);
            for (int i = 0; i < wr_addr.size() && i < exp_a.size(); i++)
                if (wr_addr[i] != exp_a[i] || wr_data[i] !== exp_d[i]) bad++;
            checks++;
            if (bad != 0 || wr_addr.size() != len || timed_out != 0 || done_cnt != 1 || accepted != 4 * len) begin
                errors++;
                $display("FAIL random_load %0d: len %0d writes %0d bad %0d done %0d accepted %0d, expected %0d writes 0 bad 1 done %0d accepted",
                         r, len, wr_addr.size(), bad, done_cnt, accepted, len, 4 * len);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b0;
        start_i      = 1'b0;
        len_words_i  = '0;
        byte_valid_i = 1'b0;
        byte_data_i  = '0;
        test_reset();
        test_basic_load();
        test_stalled_load();
        test_illegal_len();
        test_reset_mid_load();
        test_full_depth();
        test_random_loads();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
